chunk_serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor, successor to the team's fixed 4-bit combinational ripple adder.
- Adds two WIDTH-bit operands CHUNK bits per cycle, least-significant chunk first, through a registered carry. This trades latency for a short critical path and small area.
- Uses valid/ready handshakes on input and output so it can sit between pipelined datapath stages.
- Adds a subtract mode, signed-overflow detection and output back-pressure, none of which the 4-bit adder has.

---
 rtl/chunk_serial_adder.sv | 126 ++++++++++++
 tb/tb_chunk_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per
// cycle, least-significant chunk first, through a registered carry.
module chunk_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunk_serial_adder: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] s_chunk;
  logic             c_out, c_msb, last;

  // Returns {carry into top bit, carry out, sum} of one CHUNK-bit ripple.
  function automatic logic [CHUNK+1:0] ripple(input logic [CHUNK-1:0] x,
                                              input logic [CHUNK-1:0] y,
                                              input logic             ci);
    logic [CHUNK-1:0] s;
    logic             c, cm;
    s  = '0;
    c  = ci;
    cm = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      cm   = c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {cm, c, s};
  endfunction

  // Operands shift right each RUN cycle so the active chunk is always at the bottom.
  always_comb begin
    {c_msb, c_out, s_chunk} = ripple(opa[CHUNK-1:0], opb[CHUNK-1:0], carry);
    last = (k == K_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !rst && (state == IDLE);
    out_valid = !rst && (state == DONE);
  end

  // Operand registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      opa <= a;
      opb <= sub ? ~b : b;
    end else if (state == RUN) begin
      opa <= opa >> CHUNK;
      opb <= opb >> CHUNK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= sub | cin;
            k     <= '0;
          end
        end
        RUN: begin
          for (int j = 0; j < N; j++) begin
            if (k == KW'(j)) sum[j*CHUNK +: CHUNK] <= s_chunk;
          end
          carry <= c_out;
          k     <= k + 1'b1;
          if (last) begin
            cout <= c_out;
            ovf  <= c_msb ^ c_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: directed scenarios, a parameter sweep and a
// randomized run, all checked against an arithmetic reference model.
module tb_chunk_serial_adder;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] sum;

  logic        sw_iv = 1'b0, sw_cin = 1'b0, sw_sub = 1'b0, sw_or = 1'b1;
  logic [31:0] sw_a = '0, sw_b = '0;
  logic        w1_ir, w1_ov, w1_c, w1_o, w32_ir, w32_ov, w32_c, w32_o, w8_ir, w8_ov, w8_c, w8_o;
  logic [31:0] w1_s, w32_s;
  logic [7:0]  w8_s;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  chunk_serial_adder #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(w1_ir), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .out_valid(w1_ov), .out_ready(sw_or),
    .sum(w1_s), .cout(w1_c), .ovf(w1_o));

  chunk_serial_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(w32_ir), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .out_valid(w32_ov), .out_ready(sw_or),
    .sum(w32_s), .cout(w32_c), .ovf(w32_o));

  chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(w8_ir), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .sub(sw_sub), .out_valid(w8_ov), .out_ready(sw_or),
    .sum(w8_s), .cout(w8_c), .ovf(w8_o));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    longint      acc;
  } op_t;

  function automatic op_t ref_op(input logic [31:0] ra, input logic [31:0] rb,
                                 input logic rc, input logic rs, input longint acc);
    op_t         r;
    longint      sa, sb, sr;
    logic [32:0] u;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    if (rs) begin
      sr  = sa - sb;
      r.s = ra - rb;
      r.c = (ra >= rb);
    end else begin
      sr  = sa + sb + (rc ? 64'sd1 : 64'sd0);
      u   = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      r.s = u[31:0];
      r.c = u[32];
    end
    r.o   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.acc = acc;
    return r;
  endfunction

  op_t         q[$];
  longint      cyc = 0;
  logic [31:0] last_s = '0;
  logic        last_c = 1'b0, last_o = 1'b0;
  bit          known = 1'b0;
  int          n_ops = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      last_s <= '0;
      last_c <= 1'b0;
      last_o <= 1'b0;
      known  <= 1'b1;
    end else if (q.size() > 0 && (cyc - q[0].acc >= N + 1) && out_ready) begin
      last_s <= q[0].s;
      last_c <= q[0].c;
      last_o <= q[0].o;
      q.pop_front();
    end else if (q.size() == 0 && in_valid) begin
      q.push_back(ref_op(a, b, cin, sub, cyc));
      n_ops <= n_ops + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    bit eir, eov;
    eir = !rst && (q.size() == 0);
    eov = !rst && (q.size() > 0) && (cyc - q[0].acc >= N + 1);
    check("in_ready", in_ready, eir);
    check("out_valid", out_valid, eov);
    if (eov) begin
      check("sum", sum, q[0].s);
      check("cout", cout, q[0].c);
      check("ovf", ovf, q[0].o);
    end else if (!rst && known && q.size() == 0) begin
      check("idle sum hold", sum, last_s);
      check("idle cout hold", cout, last_c);
      check("idle ovf hold", ovf, last_o);
    end else if (!rst && known) begin
      check("run cout hold", cout, last_c);
      check("run ovf hold", ovf, last_o);
    end
  end

  task automatic wait_ready(input string nm);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check({nm, " ready"}, in_ready, 1);
  endtask

  task automatic do_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                       input logic tc, input logic ts,
                       input logic [31:0] es, input logic ec, input logic eo);
    int  t;
    op_t r;
    wait_ready(nm);
    r = ref_op(ta, tb_, tc, ts, 0);
    check({nm, " model"}, {r.o, r.c, r.s}, {eo, ec, es});
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check({nm, " latency"}, t, N);
    check({nm, " sum"}, sum, es);
    check({nm, " cout"}, cout, ec);
    check({nm, " ovf"}, ovf, eo);
    @(posedge clk); #1;
    check({nm, " ready after handshake"}, in_ready, 1);
    check({nm, " valid after handshake"}, out_valid, 0);
  endtask

  task automatic sweep_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tc, input logic ts, input logic [31:0] es,
                          input logic ec, input logic eo);
    int          l1 = -1, l32 = -1, l8 = -1;
    logic [31:0] s1 = '0, s32 = '0;
    logic [7:0]  s8 = '0;
    logic        c1 = 0, c32 = 0, c8 = 0, o1 = 0, o32 = 0, o8 = 0;
    check({nm, " ready"}, {w1_ir, w32_ir, w8_ir}, 3'b111);
    sw_a = ta; sw_b = tb_; sw_cin = tc; sw_sub = ts; sw_iv = 1'b1; sw_or = 1'b1;
    @(posedge clk); #1;
    sw_iv = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      if (w1_ov && l1 < 0)  begin l1 = t;  s1 = w1_s;  c1 = w1_c;  o1 = w1_o;  end
      if (w32_ov && l32 < 0) begin l32 = t; s32 = w32_s; c32 = w32_c; o32 = w32_o; end
      if (w8_ov && l8 < 0)  begin l8 = t;  s8 = w8_s;  c8 = w8_c;  o8 = w8_o;  end
    end
    check({nm, " chunk1 latency"}, l1, 32);
    check({nm, " chunk1 result"}, {o1, c1, s1}, {eo, ec, es});
    check({nm, " chunk32 latency"}, l32, 1);
    check({nm, " chunk32 result"}, {o32, c32, s32}, {eo, ec, es});
    check({nm, " width8 latency"}, l8, 4);
    check({nm, " width8 result"}, {o8, c8, s8}, {eo, ec, es[7:0]});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset in_ready", in_ready, 0);
      check("reset out_valid", out_valid, 0);
      check("reset outputs", {ovf, cout, sum}, 34'h0);
    end
    rst = 1'b0;
    #1;
    check("post-reset in_ready", in_ready, 1);
    check("post-reset out_valid", out_valid, 0);

    do_op("add wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    do_op("add ovf", 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("sub ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op("sub borrow", 32'h3, 32'h5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("sub cin0", 32'd10, 32'd3, 1'b0, 1'b1, 32'd7, 1'b1, 1'b0);
    do_op("add neg ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Back-pressure with in_valid pulsing while the result waits.
    wait_ready("bp");
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("bp latency", t, N);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp result", {ovf, cout, sum}, {2'b00, 32'h2345_6789});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready", in_ready, 1);
    check("bp release out_valid", out_valid, 0);
    check("bp idle sum", sum, 32'h2345_6789);

    // Reset on the 4th RUN cycle aborts the operation.
    wait_ready("abort");
    a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready during rst", in_ready, 0);
    check("abort outputs", {ovf, cout, sum}, 34'h0);
    rst = 1'b0;
    #1;
    check("abort idle", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort no out_valid", out_valid, 0);
    end
    check("abort sum", sum, 32'h0);

    sweep_op("sweep add", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    sweep_op("sweep sub", 32'h3, 32'h5, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Randomized traffic with back-pressure and occasional resets.
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    check("random ops accepted", n_ops > 500, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
